push_button_debouncer: RTL and testbench
========================================

// Module: push_button_debouncer
// PURPOSE
//   Conditions one raw mechanical key input into a clean, synchronous level for the push_button PIO in_port.
//   Synchronizes the asynchronous pad, rejects bounce shorter than DEBOUNCE_CYCLES, and emits one-cycle press/release strobes.
//   Keeps a wrapping press counter for diagnostics.
//   Sits between the board key pin and the Avalon PIO input stage, in the same clock domain.
// PARAMETERS
//   DEBOUNCE_CYCLES  50000  consecutive stable cycles required to accept a change (1 ms at 50 MHz); legal range 2..65535
//   SYNC_STAGES      2      synchronizer flops on key_raw; legal range 2..4
//   ACTIVE_LOW       1      1: key_raw=0 means pressed (DE-series KEYs); 0: key_raw=1 means pressed
// PORTS
//   clk            in   1   system clock
//   reset          in   1   asynchronous, active-high reset
//   key_raw        in   1   asynchronous pad input, bouncy
//   clear_count    in   1   synchronous clear of press_count
//   pressed        out  1   debounced level, 1 = pressed; drives PIO in_port
//   press_pulse    out  1   1-cycle strobe on accepted press
//   release_pulse  out  1   1-cycle strobe on accepted release
//   press_count    out  8   accepted presses, modulo 256
// BEHAVIOUR
//   Reset (async assert, sync release): synchronizer flops load the inactive pad level (ACTIVE_LOW ? 1 : 0).
//     All outputs reset to 0: pressed, press_pulse, release_pulse, press_count. The debounce counter clears; FSM enters RELEASED.
//   Sync: key_raw passes through SYNC_STAGES flops. sync_p is the last stage, polarity-normalized (1 = pressed).
//   Debounce counter: 16 bits.
//     Increments every cycle sync_p != pressed.
//     Clears to 0 on any cycle sync_p == pressed; a glitch restarts the count.
//   FSM states: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
//     RELEASED -> PRESS_PEND when sync_p=1.
//     PRESS_PEND -> RELEASED when sync_p=0 (counter clears).
//     PRESS_PEND -> PRESSED when sync_p=1 and counter==DEBOUNCE_CYCLES-1.
//     PRESSED and RELEASE_PEND mirror these transitions with sync_p inverted.
//   On entry to PRESSED, in the same clock edge:
//     pressed<=1; press_pulse<=1 for exactly one cycle; press_count<=press_count+1; counter<=0.
//   On entry to RELEASED from RELEASE_PEND: pressed<=0; release_pulse<=1 for exactly one cycle.
//   Latency: a clean pad edge at cycle 0 changes pressed after SYNC_STAGES+DEBOUNCE_CYCLES cycles.
//     This is 50002 with defaults.
//   Outputs are registered; no combinational path from key_raw to any output.
//   press_pulse and release_pulse are never high in the same cycle.
//     At least DEBOUNCE_CYCLES cycles separate consecutive strobes.
//   press_count wraps 255 -> 0 with no flag.
//   clear_count alone sets press_count to 0 at the next edge.
//   clear_count coincident with an accepted press sets press_count to 1; the press is never lost.
//   Reset mid-debounce discards the pending change. After release, a held key is re-accepted after the full latency.
//   Counter cannot overflow: it is bounded by DEBOUNCE_CYCLES-1 by construction.
// TESTING
//   Run with DEBOUNCE_CYCLES=8, SYNC_STAGES=2, ACTIVE_LOW=1.
//   1. Reset, key_raw=1 held -> all outputs 0; no strobes for 100 cycles.
//   2. key_raw 1->0 clean at cycle 0 -> pressed=1 at cycle 10, press_pulse high cycle 10 only, press_count=1.
//      Then key_raw->1 -> pressed=0 and release_pulse exactly 10 cycles later.
//   3. Bounce: key_raw low 5 cycles, high 3, low 5, high 2, then low steady.
//      -> exactly one press_pulse, 10 cycles after the final falling edge; press_count=1.
//   4. Glitch: a 7-cycle low pulse while released -> no pressed change, no strobe, count unchanged.
//   5. 257 clean presses -> press_count=1 (wrap).
//      clear_count asserted on the same cycle as a press_pulse -> press_count=1.
//      clear_count alone -> press_count=0 next cycle.
//   6. Assert reset 4 cycles into PRESS_PEND -> outputs 0 at once.
//      Key still held after release -> press accepted 10 cycles after reset deasserts.

Source files
------------

// File: rtl/push_button_debouncer_if.sv
// Signal bundle between a raw key pad and the debounced PIO input stage.
// The debouncer takes the slave side; a test driver or parent takes the master side.
interface push_button_debouncer_if;
    logic       key_raw;
    logic       clear_count;
    logic       pressed;
    logic       press_pulse;
    logic       release_pulse;
    logic [7:0] press_count;

    modport master (
        output key_raw,
        output clear_count,
        input  pressed,
        input  press_pulse,
        input  release_pulse,
        input  press_count
    );

    modport slave (
        input  key_raw,
        input  clear_count,
        output pressed,
        output press_pulse,
        output release_pulse,
        output press_count
    );
endinterface

// File: rtl/push_button_debouncer.sv
// Push-button debouncer: synchronizes a bouncy pad, accepts a level change only
// after DEBOUNCE_CYCLES consecutive stable samples, and emits one-cycle
// press/release strobes plus a wrapping 8-bit press counter.
module push_button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    push_button_debouncer_if.slave pb_if
);

    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_PRESS_PEND   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_PEND = 2'd3;

    // Pad level when the key is not pressed; also the synchronizer reset value.
    localparam logic        INACTIVE = ACTIVE_LOW;
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_p;
    logic [1:0]             state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   pressed_q, pressed_d;
    logic                   press_pulse_q, release_pulse_q;
    logic [7:0]             count_q, count_d;
    logic                   enter_pressed, enter_released;

    // Last synchronizer stage, normalized so that 1 always means pressed.
    assign sync_p = sync_q[SYNC_STAGES-1] ^ INACTIVE;

    // Next-state logic: FSM transitions, debounce counter, level and press counter.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_d        = state_q;
        enter_pressed  = 1'b0;
        enter_released = 1'b0;
        case (state_q)
            ST_RELEASED:     if (sync_p) state_d = ST_PRESS_PEND;
            ST_PRESS_PEND: begin
                if (!sync_p) begin
                    state_d = ST_RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = ST_PRESSED;
                    enter_pressed = 1'b1;
                end
            end
            ST_PRESSED:      if (!sync_p) state_d = ST_RELEASE_PEND;
            ST_RELEASE_PEND: begin
                if (sync_p) begin
                    state_d = ST_PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d        = ST_RELEASED;
                    enter_released = 1'b1;
                end
            end
            default:         state_d = ST_RELEASED;
        endcase

        // Any sample agreeing with the accepted level restarts the count, so a
        // glitch must be followed by a full clean window. Acceptance also clears it,
        // which bounds the count at DEBOUNCE_CYCLES-1.
        if ((sync_p == pressed_q) || enter_pressed || enter_released) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end

        pressed_d = pressed_q;
        if (enter_pressed)  pressed_d = 1'b1;
        if (enter_released) pressed_d = 1'b0;

        // A clear coinciding with an accepted press still records that press.
        if (pb_if.clear_count) begin
            count_d = enter_pressed ? 8'd1 : 8'd0;
        end else if (enter_pressed) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // State registers; synchronizer resets to the idle pad level, everything else to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the synchronizer resets to the inactive pad level, not 0, so an
            // active-low key is not seen as pressed straight out of reset.
            sync_q          <= {SYNC_STAGES{INACTIVE}};
            state_q         <= ST_RELEASED;
            cnt_q           <= '0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            count_q         <= '0;
        end else begin
            // NOTE: non-blocking assignments so each flop samples the pre-edge value of its neighbour.
            sync_q          <= {sync_q[SYNC_STAGES-2:0], pb_if.key_raw};
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= enter_pressed;
            release_pulse_q <= enter_released;
            count_q         <= count_d;
        end
    end

    assign pb_if.pressed       = pressed_q;
    assign pb_if.press_pulse   = press_pulse_q;
    assign pb_if.release_pulse = release_pulse_q;
    assign pb_if.press_count   = count_q;

endmodule

// File: tb/tb_push_button_debouncer.sv
// Directed bench for push_button_debouncer with DEBOUNCE_CYCLES=8, SYNC_STAGES=2,
// ACTIVE_LOW=1. Inputs are driven and outputs sampled 1 ns after each rising edge;
// edge numbers are counted from the first edge after an input change.
module tb_push_button_debouncer;

    localparam int LATENCY = 10;  // SYNC_STAGES + DEBOUNCE_CYCLES

    logic clk = 1'b0;
    logic reset;

    push_button_debouncer_if pb_if ();

    push_button_debouncer #(
        .DEBOUNCE_CYCLES (8),
        .SYNC_STAGES     (2),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pb_if (pb_if.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Observation counters accumulated by run().
    int edge_n;
    int press_seen;
    int rel_seen;
    int first_press;
    int first_rel;
    int overlap;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic clear_stats();
        edge_n      = 0;
        press_seen  = 0;
        rel_seen    = 0;
        first_press = -1;
        first_rel   = -1;
        overlap     = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            edge_n++;
            if (pb_if.press_pulse) begin
                press_seen++;
                if (first_press < 0) first_press = edge_n;
            end
            if (pb_if.release_pulse) begin
                rel_seen++;
                if (first_rel < 0) first_rel = edge_n;
            end
            if (pb_if.press_pulse && pb_if.release_pulse) overlap++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run(3);
        reset = 1'b0;
        clear_stats();
    endtask

    int mark;

    initial begin
        reset             = 1'b1;
        pb_if.key_raw     = 1'b1;
        pb_if.clear_count = 1'b0;
        clear_stats();

        // 1. Reset with key released: quiet for 100 cycles.
        do_reset();
        check("reset_pressed", int'(pb_if.pressed), 0);
        check("reset_count", int'(pb_if.press_count), 0);
        run(100);
        check("idle_press_pulses", press_seen, 0);
        check("idle_release_pulses", rel_seen, 0);
        check("idle_pressed", int'(pb_if.pressed), 0);

        // 2. Clean press then clean release.
        clear_stats();
        pb_if.key_raw = 1'b0;
        run(LATENCY - 1);
        check("press_not_early", int'(pb_if.pressed), 0);
        run(11);
        check("press_latency", first_press, LATENCY);
        check("press_pulse_width", press_seen, 1);
        check("press_level", int'(pb_if.pressed), 1);
        check("press_count_1", int'(pb_if.press_count), 1);
        clear_stats();
        pb_if.key_raw = 1'b1;
        run(20);
        check("release_latency", first_rel, LATENCY);
        check("release_pulse_width", rel_seen, 1);
        check("release_level", int'(pb_if.pressed), 0);
        check("release_count_kept", int'(pb_if.press_count), 1);

        // 3. Bounce, then steady low: one press counted from the final falling edge.
        do_reset();
        pb_if.key_raw = 1'b0; run(5);
        pb_if.key_raw = 1'b1; run(3);
        pb_if.key_raw = 1'b0; run(5);
        pb_if.key_raw = 1'b1; run(2);
        pb_if.key_raw = 1'b0;
        mark = edge_n;
        run(20);
        check("bounce_press_edge", first_press, mark + LATENCY);
        check("bounce_press_pulses", press_seen, 1);
        check("bounce_count", int'(pb_if.press_count), 1);

        // 4. Seven-cycle glitch while released: one sample short of acceptance.
        pb_if.key_raw = 1'b1;
        run(20);
        clear_stats();
        pb_if.key_raw = 1'b0; run(7);
        pb_if.key_raw = 1'b1; run(30);
        check("glitch_press_pulses", press_seen, 0);
        check("glitch_release_pulses", rel_seen, 0);
        check("glitch_pressed", int'(pb_if.pressed), 0);
        check("glitch_count", int'(pb_if.press_count), 1);

        // 5. Wrap of the press counter, then clear interactions.
        do_reset();
        for (int i = 1; i <= 257; i++) begin
            pb_if.key_raw = 1'b0; run(12);
            pb_if.key_raw = 1'b1; run(12);
            if (i == 256) check("count_wrap_256", int'(pb_if.press_count), 0);
        end
        check("count_wrap_257", int'(pb_if.press_count), 1);
        check("wrap_press_pulses", press_seen, 257);
        check("wrap_release_pulses", rel_seen, 257);
        check("no_pulse_overlap", overlap, 0);

        clear_stats();
        pb_if.key_raw = 1'b0;
        run(LATENCY - 1);
        pb_if.clear_count = 1'b1;
        run(1);
        pb_if.clear_count = 1'b0;
        check("clear_with_press_edge", first_press, LATENCY);
        check("clear_with_press_count", int'(pb_if.press_count), 1);
        pb_if.key_raw = 1'b1;
        run(12);
        pb_if.clear_count = 1'b1;
        run(1);
        pb_if.clear_count = 1'b0;
        check("clear_alone_count", int'(pb_if.press_count), 0);
        run(1);
        check("clear_alone_held", int'(pb_if.press_count), 0);

        // 6. Reset four cycles into PRESS_PEND, key kept held.
        do_reset();
        pb_if.key_raw = 1'b0;
        run(7);
        check("pend_not_pressed", int'(pb_if.pressed), 0);
        reset = 1'b1;
        #1;
        check("midreset_pressed", int'(pb_if.pressed), 0);
        check("midreset_count", int'(pb_if.press_count), 0);
        check("midreset_pulse", int'(pb_if.press_pulse), 0);
        run(2);
        reset = 1'b0;
        clear_stats();
        run(20);
        check("after_reset_press_edge", first_press, LATENCY);
        check("after_reset_pressed", int'(pb_if.pressed), 1);
        check("after_reset_count", int'(pb_if.press_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
